jtsdram_verify: RTL

- Read-back checker that runs after the SDRAM programming stage has filled all four banks.
- Sweeps every bank and word address, reading over the prog_* port, and compares each word with the expected pattern from the shared pattern source (the same ba*_data inputs the programmer used).
- Reports pass/fail, a saturating mismatch count and the first failing address.
- Shares the prog_* bus with the programmer; the top level muxes the bus on dwnld_busy/busy.

---
 rtl/jtsdram_pkg.sv | 33 +++
 rtl/jtsdram_verify_cnt.sv | 35 +++
 rtl/jtsdram_verify.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jtsdram_pkg.sv
// Shared types and helpers for the SDRAM read-back checker.
package jtsdram_pkg;

  localparam int BANK_W  = 2;
  localparam int PADDR_W = 22;
  localparam int FULL_W  = 25;

  typedef enum logic [2:0] {
    IDLE,
    EXP_LO,
    EXP_HI,
    READ,
    CHECK,
    FIN
  } state_t;

  // Advances {ba, addr}; the word address wraps to 0 after addr_end and the bank steps.
  function automatic logic [BANK_W+PADDR_W-1:0] next_addr(
    input logic [BANK_W+PADDR_W-1:0] cur,
    input logic [PADDR_W-1:0]        addr_end
  );
    logic [BANK_W-1:0]  ba;
    logic [PADDR_W-1:0] addr;
    ba   = cur[BANK_W+PADDR_W-1:PADDR_W];
    addr = cur[PADDR_W-1:0];
    if (addr == addr_end) begin
      next_addr = {ba + BANK_W'(1), {PADDR_W{1'b0}}};
    end else begin
      next_addr = {ba, addr + PADDR_W'(1)};
    end
  endfunction

endpackage

// File: rtl/jtsdram_verify_cnt.sv
// Mismatch bookkeeping: saturating error count, sticky bad flag, first failing address.
module jtsdram_verify_cnt
  import jtsdram_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic              mismatch,
  input  logic [FULL_W-1:0] addr,
  output logic              bad,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [FULL_W-1:0] first_err_addr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bad            <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (valid && mismatch) begin
      bad <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      // bad is still clear only on the first mismatch of the sweep
      if (!bad) begin
        first_err_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/jtsdram_verify.sv
// SDRAM read-back checker: sweeps all banks over the prog_* port and compares with the pattern source.
// Optional read-data signature enabled by defining JTSDRAM_VERIFY_SIG_EN.
module jtsdram_verify
  import jtsdram_pkg::*;
#(
  parameter logic [PADDR_W-1:0] ADDR_END    = 22'h3F_FFFF,
  parameter int                 ERR_W       = 16,
  parameter bit                 STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               bad,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [FULL_W-1:0]  first_err_addr,
  input  logic [15:0]        ba0_data,
  input  logic [15:0]        ba1_data,
  input  logic [15:0]        ba2_data,
  input  logic [15:0]        ba3_data,
  output logic               exp_half,
  output logic [PADDR_W-1:0] prog_addr,
  output logic [BANK_W-1:0]  prog_ba,
  output logic               prog_rd,
  output logic               prog_we,
  output logic [1:0]         prog_mask,
  input  logic [15:0]        prog_dout,
  input  logic               prog_rdy,
  output logic [15:0]        sig
);

  state_t                    state;
  logic [15:0]               exp_word;
  logic [15:0]               rdata;
  logic [15:0]               sel_data;
  logic                      mismatch;
  logic                      last_word;
  logic [BANK_W+PADDR_W-1:0] nxt;

  assign prog_we   = 1'b0;
  assign prog_mask = 2'b00;

  always_comb begin
    sel_data = ba0_data;
    case (prog_ba)
      2'd0: sel_data = ba0_data;
      2'd1: sel_data = ba1_data;
      2'd2: sel_data = ba2_data;
      2'd3: sel_data = ba3_data;
      default: sel_data = ba0_data;
    endcase
  end

  assign mismatch  = (rdata != exp_word);
  assign last_word = ({prog_ba, prog_addr} == {2'd3, ADDR_END});
  assign nxt       = next_addr({prog_ba, prog_addr}, ADDR_END);

  // start overrides every state, including an outstanding read
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      exp_half  <= 1'b0;
      prog_rd   <= 1'b0;
      prog_addr <= '0;
      prog_ba   <= '0;
      exp_word  <= '0;
      rdata     <= '0;
    end else if (start) begin
      state     <= EXP_LO;
      busy      <= 1'b1;
      done      <= 1'b0;
      exp_half  <= 1'b0;
      prog_rd   <= 1'b0;
      prog_addr <= '0;
      prog_ba   <= '0;
    end else begin
      case (state)
        IDLE: ;
        EXP_LO: begin
          exp_word[7:0] <= sel_data[7:0];
          exp_half      <= 1'b1;
          state         <= EXP_HI;
        end
        EXP_HI: begin
          exp_word[15:8] <= sel_data[15:8];
          prog_rd        <= 1'b1;
          state          <= READ;
        end
        READ: begin
          if (prog_rdy) begin
            rdata   <= prog_dout;
            prog_rd <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (last_word || (STOP_ON_ERR && mismatch)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            {prog_ba, prog_addr} <= nxt;
            exp_half             <= 1'b0;
            state                <= EXP_LO;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  jtsdram_verify_cnt #(
    .ERR_W (ERR_W)
  ) u_cnt (
    .clk            (clk),
    .rst            (rst),
    .clr            (start),
    .valid          (state == CHECK),
    .mismatch       (mismatch),
    .addr           ({prog_ba, prog_addr, 1'b0}),
    .bad            (bad),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

`ifdef JTSDRAM_VERIFY_SIG_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sig <= '0;
    end else if (state == READ && prog_rdy) begin
      sig <= {sig[14:0], sig[15]} ^ prog_dout;
    end
  end
`else
  assign sig = '0;
`endif

endmodule
